// File: rtl/spi_tc_pkg.sv
// Shared types and defaults for the SPI temperature-sample responder.
package spi_tc_pkg;

    localparam int FRAME_BITS_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DRAIN = 2'd2
    } spi_tc_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin with single-cycle rise/fall pulses.
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2,
    parameter bit RESET_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // NOTE: flops reset to the pin's idle level so reset release never looks like an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RESET_LEVEL}};
            prev_q <= RESET_LEVEL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_o =  sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[SYNC_STAGES-1] &  prev_q;

endmodule

// File: rtl/spi_tc_responder.sv
// SPI mode-0 responder streaming temperature frames MSB first.
// Optional miso_oe output is enabled by defining SPI_TC_MISO_OE_EN.
module spi_tc_responder
    import spi_tc_pkg::*;
#(
    parameter int FRAME_BITS  = FRAME_BITS_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  cs_n,
    output logic                  miso,
    input  logic [FRAME_BITS-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  frame_done,
    output logic                  frame_abort,
    output logic                  underrun
`ifdef SPI_TC_MISO_OE_EN
    ,
    output logic                  miso_oe
`endif
);

    localparam int CNT_W = $clog2(FRAME_BITS);

    logic sclk_rise_unused, sclk_fall, cs_rise, cs_fall;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_LEVEL(1'b0)) u_sclk_sync (
        .clk    (clk),
        .rst    (rst),
        .async_i(sclk),
        .rise_o (sclk_rise_unused),
        .fall_o (sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_LEVEL(1'b1)) u_cs_sync (
        .clk    (clk),
        .rst    (rst),
        .async_i(cs_n),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    spi_tc_state_e         state_q, state_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [FRAME_BITS-1:0] hold_q, hold_d;
    logic [FRAME_BITS-1:0] last_q, last_d;
    logic [FRAME_BITS-1:0] load_word;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  hold_full_q, hold_full_d;
    logic                  miso_q, miso_d;
    logic                  done_q, done_d;
    logic                  abort_q, abort_d;
    logic                  under_q, under_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            hold_q      <= '0;
            last_q      <= '0;
            cnt_q       <= '0;
            hold_full_q <= 1'b0;
            miso_q      <= 1'b0;
            done_q      <= 1'b0;
            abort_q     <= 1'b0;
            under_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            hold_full_q <= hold_full_d;
            miso_q      <= miso_d;
            done_q      <= done_d;
            abort_q     <= abort_d;
            under_q     <= under_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        hold_full_d = hold_full_q;
        miso_d      = miso_q;
        done_d      = 1'b0;
        abort_d     = 1'b0;
        under_d     = 1'b0;
        load_word   = hold_q;

        if (tx_valid && !hold_full_q) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                miso_d = 1'b0;
                if (cs_fall) begin
                    // Holding word first, then a same-cycle offer, else repeat the last frame.
                    if (hold_full_q) begin
                        load_word = hold_q;
                    end else if (tx_valid) begin
                        load_word = tx_data;
                    end else begin
                        load_word = last_q;
                        under_d   = 1'b1;
                    end
                    hold_full_d = 1'b0;
                    shift_d     = load_word;
                    last_d      = load_word;
                    miso_d      = load_word[FRAME_BITS-1];
                    cnt_d       = '0;
                    state_d     = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    abort_d = 1'b1;
                    miso_d  = 1'b0;
                    state_d = IDLE;
                end else if (sclk_fall) begin
                    if (cnt_q == CNT_W'(FRAME_BITS - 1)) begin
                        miso_d  = 1'b0;
                        state_d = DRAIN;
                    end else begin
                        shift_d = shift_q << 1;
                        miso_d  = shift_q[FRAME_BITS-2];
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                miso_d = 1'b0;
                if (cs_rise) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                miso_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign miso        = miso_q;
    assign tx_ready    = ~hold_full_q;
    assign frame_done  = done_q;
    assign frame_abort = abort_q;
    assign underrun    = under_q;

`ifdef SPI_TC_MISO_OE_EN
    assign miso_oe = (state_q != IDLE);
`endif

endmodule

// File: tb/tb_spi_tc_responder.sv
// Directed self-checking bench for spi_tc_responder acting as a mode-0 SPI master.
module tb_spi_tc_responder;

    localparam int FB = 16;
    localparam int SS = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          sclk;
    logic          cs_n;
    logic          miso;
    logic [FB-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          frame_done;
    logic          frame_abort;
    logic          underrun;
`ifdef SPI_TC_MISO_OE_EN
    logic          miso_oe;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt  = 0;
    int abort_cnt = 0;
    int under_cnt = 0;
    int b_done, b_abort, b_under;
    logic [31:0] rx;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done === 1'b1)  done_cnt++;
        if (frame_abort === 1'b1) abort_cnt++;
        if (underrun === 1'b1)    under_cnt++;
    end

    spi_tc_responder #(.FRAME_BITS(FB), .SYNC_STAGES(SS)) dut (
        .clk        (clk),
        .rst        (rst),
        .sclk       (sclk),
        .cs_n       (cs_n),
        .miso       (miso),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .frame_done (frame_done),
        .frame_abort(frame_abort),
        .underrun   (underrun)
`ifdef SPI_TC_MISO_OE_EN
        ,
        .miso_oe    (miso_oe)
`endif
    );

    task automatic snap();
        b_done  = done_cnt;
        b_abort = abort_cnt;
        b_under = under_cnt;
    endtask

    task automatic cs_low();
        @(negedge clk);
        cs_n = 1'b0;
        #500;
    endtask

    task automatic cs_high();
        cs_n = 1'b1;
        #500;
    endtask

    // 1 MHz sclk: master samples miso as it raises sclk
    task automatic shift_bits(input int n, output logic [31:0] data);
        data = '0;
        for (int i = 0; i < n; i++) begin
            sclk = 1'b1;
            data = {data[30:0], miso};
            #500;
            sclk = 1'b0;
            #500;
        end
    endtask

    task automatic load_word(input logic [FB-1:0] w);
        @(negedge clk);
        n_tests++;
        if (tx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL load_ready_before: tx_ready=%b expected 1", tx_ready);
        end
        tx_valid = 1'b1;
        tx_data  = w;
        @(negedge clk);
        tx_valid = 1'b0;
        n_tests++;
        if (tx_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL load_ready_after: tx_ready=%b expected 0", tx_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; tx_valid = 1'b0; tx_data = '0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({miso, tx_ready, frame_done, frame_abort, underrun} !== 5'b01000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 01000",
                     {miso, tx_ready, frame_done, frame_abort, underrun});
        end
`ifdef SPI_TC_MISO_OE_EN
        n_tests++;
        if (miso_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_oe: miso_oe=%b expected 0", miso_oe);
        end
`endif
        rst = 1'b0;
        repeat (10) @(negedge clk);
        n_tests++;
        if (done_cnt + abort_cnt + under_cnt !== 0) begin
            n_fail++;
            $display("FAIL reset_release_pulses: got %0d expected 0", done_cnt + abort_cnt + under_cnt);
        end
    endtask

    task automatic test_basic();
        load_word(16'h1A38);
        snap();
        cs_low();
        n_tests++;
        if (tx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_ready_after_cs: tx_ready=%b expected 1", tx_ready);
        end
`ifdef SPI_TC_MISO_OE_EN
        n_tests++;
        if (miso_oe !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_oe: miso_oe=%b expected 1", miso_oe);
        end
`endif
        shift_bits(16, rx);
        n_tests++;
        if (rx[15:0] !== 16'h1A38) begin
            n_fail++;
            $display("FAIL basic_data: got %h expected 1a38", rx[15:0]);
        end
        n_tests++;
        if (miso !== 1'b0 || done_cnt != b_done) begin
            n_fail++;
            $display("FAIL basic_drain: miso=%b done=%0d expected 0 0", miso, done_cnt - b_done);
        end
        cs_high();
        n_tests++;
        if (done_cnt - b_done != 1 || abort_cnt != b_abort || under_cnt != b_under) begin
            n_fail++;
            $display("FAIL basic_pulses: done=%0d abort=%0d under=%0d expected 1 0 0",
                     done_cnt - b_done, abort_cnt - b_abort, under_cnt - b_under);
        end
    endtask

    task automatic test_repeat();
        snap();
        cs_low();
        shift_bits(16, rx);
        cs_high();
        n_tests++;
        if (rx[15:0] !== 16'h1A38) begin
            n_fail++;
            $display("FAIL repeat_data: got %h expected 1a38", rx[15:0]);
        end
        n_tests++;
        if (under_cnt - b_under != 1 || done_cnt - b_done != 1) begin
            n_fail++;
            $display("FAIL repeat_pulses: under=%0d done=%0d expected 1 1",
                     under_cnt - b_under, done_cnt - b_done);
        end
    endtask

    task automatic test_abort();
        snap();
        cs_low();
        load_word(16'h0F0F);
        shift_bits(5, rx);
        cs_high();
        n_tests++;
        if (rx[4:0] !== 5'b00011) begin
            n_fail++;
            $display("FAIL abort_partial: got %b expected 00011", rx[4:0]);
        end
        n_tests++;
        if (abort_cnt - b_abort != 1 || done_cnt != b_done || under_cnt - b_under != 1) begin
            n_fail++;
            $display("FAIL abort_pulses: abort=%0d done=%0d under=%0d expected 1 0 1",
                     abort_cnt - b_abort, done_cnt - b_done, under_cnt - b_under);
        end
        snap();
        cs_low();
        shift_bits(16, rx);
        cs_high();
        n_tests++;
        if (rx[15:0] !== 16'h0F0F || under_cnt != b_under || done_cnt - b_done != 1) begin
            n_fail++;
            $display("FAIL abort_next: data=%h under=%0d done=%0d expected 0f0f 0 1",
                     rx[15:0], under_cnt - b_under, done_cnt - b_done);
        end
    endtask

    task automatic test_bypass();
        snap();
        @(negedge clk);
        cs_n = 1'b0;
        repeat (SS) @(negedge clk);
        n_tests++;
        if (tx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bypass_ready: tx_ready=%b expected 1", tx_ready);
        end
        tx_valid = 1'b1;
        tx_data  = 16'h0004;
        @(negedge clk);
        tx_valid = 1'b0;
        #490;
        shift_bits(16, rx);
        cs_high();
        n_tests++;
        if (rx[15:0] !== 16'h0004 || under_cnt != b_under || done_cnt - b_done != 1) begin
            n_fail++;
            $display("FAIL bypass_frame: data=%h under=%0d done=%0d expected 0004 0 1",
                     rx[15:0], under_cnt - b_under, done_cnt - b_done);
        end
        n_tests++;
        if (tx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bypass_empty_after: tx_ready=%b expected 1", tx_ready);
        end
    endtask

    task automatic test_overclock();
        snap();
        cs_low();
        shift_bits(20, rx);
        n_tests++;
        if (rx[19:0] !== 20'h00040) begin
            n_fail++;
            $display("FAIL overclock_data: got %h expected 00040", rx[19:0]);
        end
        n_tests++;
        if (done_cnt != b_done) begin
            n_fail++;
            $display("FAIL overclock_early_done: done=%0d expected 0", done_cnt - b_done);
        end
        cs_high();
        n_tests++;
        if (done_cnt - b_done != 1 || under_cnt - b_under != 1 || abort_cnt != b_abort) begin
            n_fail++;
            $display("FAIL overclock_pulses: done=%0d under=%0d abort=%0d expected 1 1 0",
                     done_cnt - b_done, under_cnt - b_under, abort_cnt - b_abort);
        end
    endtask

    task automatic test_holdoff();
        bit ready_seen;
        load_word(16'hAAAA);
        ready_seen = 1'b0;
        tx_valid = 1'b1;
        tx_data  = 16'h5555;
        repeat (4) begin
            @(negedge clk);
            if (tx_ready !== 1'b0) ready_seen = 1'b1;
        end
        tx_valid = 1'b0;
        n_tests++;
        if (ready_seen) begin
            n_fail++;
            $display("FAIL holdoff_ready: tx_ready rose while full, expected 0");
        end
        snap();
        @(negedge clk);
        cs_n = 1'b0;
        repeat (SS) @(negedge clk);
        n_tests++;
        if (miso !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_early: miso=%b expected 0", miso);
        end
        repeat (2) @(negedge clk);
        n_tests++;
        if (miso !== 1'b1) begin
            n_fail++;
            $display("FAIL latency_msb: miso=%b expected 1", miso);
        end
        #460;
        shift_bits(16, rx);
        cs_high();
        n_tests++;
        if (rx[15:0] !== 16'hAAAA || under_cnt != b_under || done_cnt - b_done != 1) begin
            n_fail++;
            $display("FAIL holdoff_frame: data=%h under=%0d done=%0d expected aaaa 0 1",
                     rx[15:0], under_cnt - b_under, done_cnt - b_done);
        end
    endtask

    task automatic test_reset_mid_frame();
        load_word(16'hC3C3);
        cs_low();
        load_word(16'h7777);
        shift_bits(8, rx);
        n_tests++;
        if (rx[7:0] !== 8'hC3) begin
            n_fail++;
            $display("FAIL midrst_partial: got %h expected c3", rx[7:0]);
        end
        snap();
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_tests++;
        if (miso !== 1'b0 || tx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_immediate: miso=%b tx_ready=%b expected 0 1", miso, tx_ready);
        end
        cs_n = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        n_tests++;
        if (done_cnt != b_done || abort_cnt != b_abort || under_cnt != b_under) begin
            n_fail++;
            $display("FAIL midrst_pulses: done=%0d abort=%0d under=%0d expected 0 0 0",
                     done_cnt - b_done, abort_cnt - b_abort, under_cnt - b_under);
        end
        snap();
        cs_low();
        shift_bits(16, rx);
        cs_high();
        n_tests++;
        if (rx[15:0] !== 16'h0000 || under_cnt - b_under != 1 || done_cnt - b_done != 1) begin
            n_fail++;
            $display("FAIL midrst_next: data=%h under=%0d done=%0d expected 0000 1 1",
                     rx[15:0], under_cnt - b_under, done_cnt - b_done);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_repeat();
        test_abort();
        test_bypass();
        test_overclock();
        test_holdoff();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
